// File: rtl/decode_execute_pipe.sv
// decode_execute_pipe
//   Decode-to-execute pipeline register with a valid/ready handshake and a
//   2-entry buffer (output register plus one skid entry). While an
//   instruction waits in either entry, its source operands are refreshed
//   from the writeback port so a stalled instruction never carries a stale
//   register value.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. in_ready = !skid_valid, taken from registered state only, so
//   there is no combinational path from out_ready to in_ready. The producer
//   may change its payload only after a transfer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop every held and incoming instruction
//   in_valid/in_ready   decode side handshake
//   in_pc .. in_ctrl    decode payload (operands, addresses, control bundle)
//   wb_en/wb_rd/wb_data writeback port used for operand refresh
//   out_valid/out_ready execute side handshake
//   out_pc .. out_ctrl  registered payload, all-zero when out_valid=0
//   stall_cnt/flush_cnt performance counters
//
// Configuration:
//   DECODE_EXECUTE_PIPE_PERF_EN  when defined, stall_cnt and flush_cnt are
//   saturating counters; otherwise both are tied to 0.
module decode_execute_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 14,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_pc_plus4,
  input  logic [DATA_W-1:0] in_rd1,
  input  logic [DATA_W-1:0] in_rd2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_pc_plus4,
  output logic [DATA_W-1:0] out_rd1,
  output logic [DATA_W-1:0] out_rd2,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [REG_AW-1:0] out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t out_q, skid_q;
  logic   out_valid_q, skid_valid_q;
  entry_t in_e, in_byp, out_byp, skid_byp;
  logic   accept, load_out;

  // Writeback refresh. Register 0 is hard-wired and never refreshed. Empty
  // entries are held at zero (rs1=rs2=0), so they can never match either.
  function automatic entry_t bypass(input entry_t e, input logic en,
                                    input logic [REG_AW-1:0] rd,
                                    input logic [DATA_W-1:0] data);
    entry_t r;
    r = e;
    if (en && (rd != '0)) begin
      if (e.rs1 == rd) r.rd1 = data;
      if (e.rs2 == rd) r.rd2 = data;
    end
    return r;
  endfunction

  always_comb begin
    in_e          = '0;
    in_e.pc       = in_pc;
    in_e.pc_plus4 = in_pc_plus4;
    in_e.rd1      = in_rd1;
    in_e.rd2      = in_rd2;
    in_e.imm      = in_imm;
    in_e.rs1      = in_rs1;
    in_e.rs2      = in_rs2;
    in_e.rd       = in_rd;
    in_e.ctrl     = in_ctrl;
  end

  assign in_byp   = bypass(in_e,   wb_en, wb_rd, wb_data);
  assign out_byp  = bypass(out_q,  wb_en, wb_rd, wb_data);
  assign skid_byp = bypass(skid_q, wb_en, wb_rd, wb_data);

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  // Output register may take a new entry when empty or being consumed.
  assign load_out = !out_valid_q || out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (load_out) begin
      if (skid_valid_q) begin
        // in_ready is low while the skid is full, so nothing new arrives.
        out_q        <= skid_byp;
        out_valid_q  <= 1'b1;
        skid_q       <= '0;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= in_byp;
        out_valid_q <= 1'b1;
      end else begin
        out_q       <= '0;
        out_valid_q <= 1'b0;
      end
    end else begin
      out_q <= out_byp;
      if (accept) begin
        skid_q       <= in_byp;
        skid_valid_q <= 1'b1;
      end else begin
        skid_q <= skid_byp;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_q.pc;
  assign out_pc_plus4 = out_q.pc_plus4;
  assign out_rd1      = out_q.rd1;
  assign out_rd2      = out_q.rd2;
  assign out_imm      = out_q.imm;
  assign out_rs1      = out_q.rs1;
  assign out_rs2      = out_q.rs2;
  assign out_rd       = out_q.rd;
  assign out_ctrl     = out_q.ctrl;

`ifdef DECODE_EXECUTE_PIPE_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid_q && !out_ready && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush && (out_valid_q || skid_valid_q) && (flush_q != '1))
        flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
